// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID->EX pipeline stage with two-entry skid buffer, flush and stats
//
// Carries a decode payload to execute over a valid/ready handshake. A main
// register feeds EX and a skid register absorbs the beat in flight when EX
// back-pressures, so in_ready can be a pure register output. Flush empties
// both entries and zeroes their payloads.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_data/in_ready    decode-side handshake and payload
//   out_valid/out_data/out_ready EX-side handshake and payload (zero when idle)
//   flush                    synchronous kill of all held entries
//   level                    entries held (0..2)
//   flush_count              saturating count of valid entries discarded by flush
//   stall_count              saturating count of cycles with out_valid & !out_ready
module id_ex_pipe_stage #(
   parameter int PAYLOAD_W = 133,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 out_ready,
   input  logic                 flush,
   output logic [1:0]           level,
   output logic [CNT_W-1:0]     flush_count,
   output logic [CNT_W-1:0]     stall_count
);

   logic                 skid_valid;
   logic [PAYLOAD_W-1:0] skid_data;
   logic                 in_fire;
   logic                 out_fire;
   logic [CNT_W:0]       flush_sum;

   // in_ready depends only on the skid flop, never on out_ready or flush.
   assign in_ready = ~skid_valid;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign level    = {1'b0, out_valid} + {1'b0, skid_valid};

   // One extra bit catches the carry so the counter can clamp at all-ones.
   assign flush_sum = {1'b0, flush_count}
                    + {{CNT_W{1'b0}}, out_valid}
                    + {{CNT_W{1'b0}}, skid_valid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         skid_valid  <= 1'b0;
         skid_data   <= '0;
         flush_count <= '0;
         stall_count <= '0;
      end else begin
         // Stall accounting also runs in the flush cycle.
         if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;

         if (flush) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            flush_count <= flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
         end else if (skid_valid) begin
            // Input is blocked; the skid entry moves up once EX takes the head.
            if (out_fire) begin
               out_data   <= skid_data;
               out_valid  <= 1'b1;
               skid_valid <= 1'b0;
               skid_data  <= '0;
            end
         end else if (!out_valid || out_ready) begin
            out_valid <= in_fire;
            out_data  <= in_fire ? in_data : '0;
         end else if (in_fire) begin
            // Head is stalled: park the beat that was already in flight.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb/tb_id_ex_pipe_stage.sv - scoreboard bench for id_ex_pipe_stage
module tb_id_ex_pipe_stage;

   localparam int PW = 133;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;

   logic          in_ready, out_valid;
   logic [PW-1:0] out_data;
   logic [1:0]    level;
   logic [15:0]   flush_count, stall_count;

   logic          s_in_ready, s_out_valid;
   logic [PW-1:0] s_out_data;
   logic [1:0]    s_level;
   logic [1:0]    s_flush_count, s_stall_count;

   id_ex_pipe_stage #(.PAYLOAD_W(PW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
      .level(level), .flush_count(flush_count), .stall_count(stall_count)
   );

   id_ex_pipe_stage #(.PAYLOAD_W(PW), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
      .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready), .flush(flush),
      .level(s_level), .flush_count(s_flush_count), .stall_count(s_stall_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [PW-1:0] exp_q[$];
   int            lvl_at_check = 0;
   longint        stall_ref = 0;
   longint        flush_ref = 0;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] sat(input longint v, input longint maxv);
      return (v > maxv) ? PW'(maxv) : PW'(v);
   endfunction

   function automatic logic [PW-1:0] mk(input logic [31:0] inst, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm,
                                        input logic [4:0] ty);
      return {inst, a, b, imm, ty};
   endfunction

   function automatic logic [PW-1:0] rnd_payload();
      return mk($urandom, $urandom, $urandom, $urandom, 5'($urandom));
   endfunction

   // Monitor: the stage behaves as a FIFO of at most two accepted beats whose
   // head is presented to EX. It compares, then applies this cycle's
   // out_ready / flush to the model.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_ref = 0;
         flush_ref = 0;
         lvl_at_check = 0;
      end else begin
         check("out_valid", PW'(out_valid), PW'(exp_q.size() > 0));
         if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
         else                  check("out_data_idle_zero", out_data, '0);
         check("level", PW'(level), PW'(exp_q.size()));
         check("in_ready", PW'(in_ready), PW'(exp_q.size() < 2));
         check("stall_count", PW'(stall_count), sat(stall_ref, 65535));
         check("flush_count", PW'(flush_count), sat(flush_ref, 65535));
         check("sat_stall_count", PW'(s_stall_count), sat(stall_ref, 3));
         check("sat_flush_count", PW'(s_flush_count), sat(flush_ref, 3));
         check("sat_level", PW'(s_level), PW'(exp_q.size()));

         lvl_at_check = exp_q.size();
         if (exp_q.size() > 0 && !out_ready) stall_ref++;
         if (flush) begin
            flush_ref += exp_q.size();
            exp_q.delete();
         end else if (exp_q.size() > 0 && out_ready) begin
            void'(exp_q.pop_front());
         end
      end
   end

   // Drive one cycle of inputs; at the edge, record the beat if the stage takes it.
   task automatic cyc(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      if (!rst && v && !f && lvl_at_check < 2) exp_q.push_back(d);
      #1;
   endtask

   initial begin
      // Reset values
      #1;
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_in_ready", PW'(in_ready), PW'(1));
      check("rst_level", PW'(level), '0);
      check("rst_flush_count", PW'(flush_count), '0);
      check("rst_stall_count", PW'(stall_count), '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Streaming, one beat per cycle
      for (int i = 0; i < 5; i++) cyc(1'b1, mk(32'h13 + 32'(i), 32'(i), 32'(i * 3), 32'hff, 5'(i)), 1'b1, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // Back-pressure for 4 cycles mid-stream
      for (int i = 0; i < 10; i++)
         cyc(1'b1, mk(32'h100 + 32'(i), 32'hA, 32'hB, 32'hC, 5'h3), !(i >= 2 && i < 6), 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // Fill to level 2, then flush with a beat offered in the same cycle
      for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h200 + 32'(i), 0, 0, 0, 0), 1'b0, 1'b0);
      cyc(1'b1, mk(32'hDEAD, 1, 2, 3, 4), 1'b0, 1'b1);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

      // Consecutive flushes on an empty stage
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Long stall drives the narrow counter into saturation
      cyc(1'b1, mk(32'h300, 0, 0, 0, 1), 1'b1, 1'b0);
      repeat (6) cyc(1'b0, '0, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset while two entries are held
      for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h400 + 32'(i), 0, 0, 0, 2), 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", PW'(out_valid), '0);
      check("arst_out_data", out_data, '0);
      check("arst_in_ready", PW'(in_ready), PW'(1));
      check("arst_level", PW'(level), '0);
      check("arst_stall_count", PW'(stall_count), '0);
      check("arst_flush_count", PW'(flush_count), '0);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1'b1, mk(32'h500, 5, 5, 5, 5), 1'b1, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), rnd_payload(), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 19) == 0));
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID→EX pipeline stage that carries a generic payload (instruction, operands, immediate, type) with a valid/ready handshake. It sits between decode and execute. A two-entry skid buffer lets back-pressure from EX stall decode without combinational ready paths and without losing throughput. A synchronous flush kills everything held and forces payloads to zero rather than X. Saturating counters report flushed entries and stall cycles for performance debug.

## Interface
- PAYLOAD_W, default 133: payload width; default packs inst(32), opA(32), opB(32), imm(32), type(5), MSB→LSB.
- CNT_W, default 16: width of the statistics counters.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode presents a beat.
- in_data  in  PAYLOAD_W  decode payload.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- out_valid  out  1  EX-side beat present.
- out_data  out  PAYLOAD_W  EX-side payload; zero whenever out_valid=0.
- out_ready  in  1  EX accepts the beat.
- flush  in  1  branch-kill; synchronous, highest priority.
- level  out  2  entries held (0..2) = out_valid + skid_valid.
- flush_count  out  CNT_W  total valid entries discarded by flush; saturating.
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- Storage: main register (out_valid, out_data) and skid register (skid_valid, skid_data).
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Priority per clock edge: flush > normal update.
- Flush:
  - out_valid←0, skid_valid←0, out_data←0, skid_data←0.
  - A beat accepted in the flush cycle is discarded.
  - flush_count += out_valid + skid_valid, saturating at all-ones.
- Normal, skid_valid=1:
  - in_ready=0, so no input is accepted.
  - If out_fire: out_data←skid_data, out_valid←1, skid_valid←0, skid_data←0.
  - Else hold.
- Normal, skid_valid=0, and (out_valid=0 or out_ready=1):
  - out_valid←in_fire.
  - out_data←in_data if in_fire, else 0.
- Normal, skid_valid=0, out_valid=1, out_ready=0:
  - out holds.
  - If in_fire: skid_data←in_data, skid_valid←1.
- Ordering: payloads leave in strict acceptance order; no duplication or loss except by flush.
- stall_count increments each cycle with out_valid & !out_ready, including the flush cycle, saturating.
- Counters clear only on rst.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - out_valid=0, out_data=0, skid_valid=0, in_ready=1.
  - level=0, flush_count=0, stall_count=0.
- Latency: in_fire at edge N → out_valid=1 with that payload after edge N, visible in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- out_ready deasserting costs no throughput: skid absorbs the one beat in flight.
- in_ready is a pure register output: no combinational path from out_ready or flush.
- When out_ready rises with skid full:
  - skid drains to out at that edge.
  - in_ready=1 from the next cycle.
- Flush takes effect at the edge where it is sampled:
  - Next cycle: out_valid=0, level=0, in_ready=1.
  - Flush held for several cycles keeps the stage empty.
- Flush and rst together: rst wins; counters are zero.
- rst mid-transfer: all held beats are lost; no flush_count increment.

## Test plan
- Streaming: out_ready=1; send inst=0x00000013…0x00000017 back-to-back → same five payloads, one per cycle, 1-cycle latency; level ≤1; stall_count=0.
- Back-pressure: hold out_ready=0 for 4 cycles during streaming → level reaches 2, in_ready drops one cycle after skid fills, stall_count=4; after release, order is preserved with no loss.
- Flush full: level=2, flush=1 for one cycle with in_valid=1 → next cycle out_valid=0, out_data=0, level=0; flush_count=2; the incoming beat never appears.
- Flush on empty plus consecutive flushes: flush for 3 cycles with nothing held → flush_count unchanged, out_data stays 0.
- Saturation: CNT_W=2; stall 6 cycles → stall_count=3 and holds.
- Async reset: assert rst between clock edges while level=2 → outputs reach reset values immediately; after release, the first accepted beat appears after one cycle.
